llsc_mem_ctrl: RTL and testbench
================================

// Module: llsc_mem_ctrl
// PURPOSE
//  MEM-stage controller for LL/SC atomic accesses; sits directly upstream of the LLbit register.
//  - Runs the data-bus req/ack handshake for LL loads and SC stores.
//  - Resolves the current LLbit, forwarding any in-flight WB-stage write ahead of the register.
//  - Produces the LLbit write (value + enable) and the SC success/fail result.
//  - Stalls the pipeline while a bus access is outstanding.
// PARAMETERS
//  BUS_TIMEOUT  255  max cycles to wait for bus_ack before abort; must be >=1; counter width = $clog2(BUS_TIMEOUT+1)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  flush         in   1   exception flush; abort current op
//  op_valid      in   1   MEM-stage op present
//  op_ll         in   1   op is LL (qualified by op_valid)
//  op_sc         in   1   op is SC (qualified by op_valid); op_ll and op_sc are never both high
//  op_sw         in   1   op is ordinary store; used only by the optional feature
//  addr          in   32  effective address, word aligned
//  wdata         in   32  SC store data
//  llbit_cur     in   1   current LLbit register value
//  wb_llbit_we   in   1   WB stage writing LLbit this cycle
//  wb_llbit_val  in   1   value of that WB write
//  bus_req       out  1   bus request
//  bus_we        out  1   1 = write
//  bus_addr      out  32  bus address
//  bus_wdata     out  32  bus write data
//  bus_ack       in   1   bus completes access this cycle
//  bus_rdata     in   32  read data; valid with bus_ack
//  result        out  32  LL: loaded word; SC: 1 on success, 0 on fail
//  result_valid  out  1   one-cycle completion pulse
//  llbit_we_o    out  1   LLbit write enable to the LLbit register
//  llbit_val_o   out  1   LLbit write value
//  bus_err       out  1   one-cycle pulse on timeout
//  stall_req     out  1   pipeline stall request
// BEHAVIOUR
//  Reset: state=IDLE; every registered output = 0 (bus_*, result, result_valid, llbit_*, bus_err); count=0.
//  Effective LLbit: eff_ll = wb_llbit_we ? wb_llbit_val : llbit_cur.
//  States: IDLE, BUS, DONE.
//  IDLE, accept when op_valid & (op_ll | (op_sc & eff_ll)):
//   - latch addr/wdata/type; next cycle bus_req=1, bus_we=op_sc; state->BUS; count=0.
//  IDLE, failing SC (op_valid & op_sc & !eff_ll):
//   - no bus access; next cycle result=0, result_valid=1, llbit_we_o=1, llbit_val_o=0.
//   - stall_req stays low.
//  BUS: bus outputs are held stable until the cycle after ack.
//   - On bus_ack: bus_req drops next cycle; state->DONE.
//   - DONE cycle: result_valid=1; LL: result=bus_rdata (captured), llbit 1; SC: result=1, llbit 0.
//   - count increments each cycle without ack; at count==BUS_TIMEOUT-1 with no ack:
//     bus_req drops, bus_err pulses, state->IDLE; no result_valid, no llbit write.
//  DONE -> IDLE unconditionally.
//  Latency: op accepted at T, ack at A -> result_valid and llbit_we_o at A+1.
//   - Minimum LL/SC latency 2 cycles (ack at T+1).
//  stall_req: combinational; high in IDLE when an accept condition holds, high throughout BUS, low in DONE.
//  flush (any state): next cycle state=IDLE, bus_req=0; pending result and llbit write suppressed.
//   - flush overrides a simultaneous bus_ack.
//   - flush in IDLE blocks acceptance that cycle.
//  Result/llbit pulses are exactly one cycle; never asserted together with bus_err.
// CONFIGURATION
//  LLSC_ADDR_CHECK_EN defined:
//   - link_addr[31:2] captured in DONE of a successful LL.
//   - SC with addr[31:2] != link_addr fails like eff_ll=0.
//   - op_valid & op_sw to link_addr pulses llbit_we_o with llbit_val_o=0 next cycle; no stall.
//  Not defined: no link register; addr does not affect SC outcome; op_sw ignored.
// TESTING
//  LL addr=0x100, ack at T+2, rdata=0xDEADBEEF -> result=0xDEADBEEF, llbit_we_o/llbit_val_o=1 at T+3, stall T..T+2.
//  SC with llbit_cur=1, wdata=0x55, ack at T+1 -> bus_we=1, bus_wdata=0x55, result=1, llbit_val_o=0 at T+2.
//  SC with llbit_cur=1 but wb_llbit_we=1/val=0 same cycle -> no bus_req, result=0, stall_req=0.
//  LL, no ack, BUS_TIMEOUT=4 -> bus_err pulse, bus_req low, no llbit write, back to IDLE.
//  flush during BUS, coincident with bus_ack -> no result_valid, no llbit_we_o, IDLE next cycle.
//  ADDR_CHECK_EN: LL 0x200, SW 0x200, SC 0x200 -> llbit cleared by SW; if LLbit reg applied it, SC result=0 (LL 0x200 then SC 0x204 -> 0).

Source files
------------

// File: rtl/llsc_mem_ctrl.sv
// rtl/llsc_mem_ctrl.sv - MEM-stage LL/SC controller: bus handshake, LLbit forwarding and SC resolution.
// Optional link-address check enabled by defining LLSC_ADDR_CHECK_EN.
module llsc_mem_ctrl #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic        op_ll,
  input  logic        op_sc,
  input  logic        op_sw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        llbit_cur,
  input  logic        wb_llbit_we,
  input  logic        wb_llbit_val,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        llbit_we_o,
  output logic        llbit_val_o,
  output logic        bus_err,
  output logic        stall_req
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          is_ll;

  logic eff_ll;
  logic sc_addr_ok;
  logic sw_kill;
  logic accept;
  logic sc_fail;

  // A WB-stage LLbit write has not reached the register yet, so it takes priority.
  assign eff_ll = wb_llbit_we ? wb_llbit_val : llbit_cur;

`ifdef LLSC_ADDR_CHECK_EN
  logic [29:0] link_addr;
  logic        link_valid;

  assign sc_addr_ok = link_valid && (addr[31:2] == link_addr);
  assign sw_kill    = op_valid && op_sw && !op_ll && !op_sc &&
                      link_valid && (addr[31:2] == link_addr);
`else
  logic unused_sw;

  assign unused_sw  = op_sw;
  assign sc_addr_ok = 1'b1;
  assign sw_kill    = 1'b0;
`endif

  assign accept  = op_valid && !flush && (op_ll || (op_sc && eff_ll && sc_addr_ok));
  assign sc_fail = op_valid && !flush && op_sc && !(eff_ll && sc_addr_ok);

  assign stall_req = ((state == S_IDLE) && accept) || (state == S_BUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      is_ll        <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      llbit_we_o   <= 1'b0;
      llbit_val_o  <= 1'b0;
      bus_err      <= 1'b0;
`ifdef LLSC_ADDR_CHECK_EN
      link_addr    <= '0;
      link_valid   <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      llbit_we_o   <= 1'b0;
      bus_err      <= 1'b0;
      if (flush) begin
        // Flush wins over everything, including a bus_ack in the same cycle.
        state   <= S_IDLE;
        bus_req <= 1'b0;
        count   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state     <= S_BUS;
              bus_req   <= 1'b1;
              bus_we    <= op_sc;
              bus_addr  <= addr;
              bus_wdata <= wdata;
              is_ll     <= op_ll;
              count     <= '0;
            end else if (sc_fail) begin
              result       <= '0;
              result_valid <= 1'b1;
              llbit_we_o   <= 1'b1;
              llbit_val_o  <= 1'b0;
            end else if (sw_kill) begin
              llbit_we_o  <= 1'b1;
              llbit_val_o <= 1'b0;
            end
          end
          S_BUS: begin
            if (bus_ack) begin
              state        <= S_DONE;
              bus_req      <= 1'b0;
              result       <= is_ll ? bus_rdata : 32'd1;
              result_valid <= 1'b1;
              llbit_we_o   <= 1'b1;
              llbit_val_o  <= is_ll;
            end else if (count == CW'(BUS_TIMEOUT - 1)) begin
              state   <= S_IDLE;
              bus_req <= 1'b0;
              bus_err <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
`ifdef LLSC_ADDR_CHECK_EN
            if (is_ll) begin
              link_addr  <= bus_addr[31:2];
              link_valid <= 1'b1;
            end
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// tb/tb_llsc_mem_ctrl.sv - self-checking bench for llsc_mem_ctrl with an op-level reference model.
module tb_llsc_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic        op_ll;
  logic        op_sc;
  logic        op_sw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        llbit_cur;
  logic        wb_llbit_we;
  logic        wb_llbit_val;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] result;
  logic        result_valid;
  logic        llbit_we_o;
  logic        llbit_val_o;
  logic        bus_err;
  logic        stall_req;

  llsc_mem_ctrl #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_ll(op_ll), .op_sc(op_sc),
    .op_sw(op_sw), .addr(addr), .wdata(wdata), .llbit_cur(llbit_cur), .wb_llbit_we(wb_llbit_we),
    .wb_llbit_val(wb_llbit_val), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .result(result),
    .result_valid(result_valid), .llbit_we_o(llbit_we_o), .llbit_val_o(llbit_val_o),
    .bus_err(bus_err), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the LLbit register and link address that sit around the controller.
  logic        model_ll = 1'b0;
  logic [29:0] m_link = '0;
  logic        m_link_v = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid     = 1'b0;
    op_ll        = 1'b0;
    op_sc        = 1'b0;
    op_sw        = 1'b0;
    wb_llbit_we  = 1'b0;
    wb_llbit_val = 1'b0;
    bus_ack      = 1'b0;
    flush        = 1'b0;
    llbit_cur    = model_ll;
  endtask

  // kind: 0=LL 1=SC 2=SW; ack_lat: bus cycle (1..TO) that sees bus_ack, 0 = never.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_lat, input logic [31:0] rd,
                        input logic wbwe, input logic wbval);
    logic eff, link_ok, acc, sc_bad, sw_hit, done;
    eff = wbwe ? wbval : model_ll;
`ifdef LLSC_ADDR_CHECK_EN
    link_ok = m_link_v && (a[31:2] == m_link);
    sw_hit  = (kind == 2) && m_link_v && (a[31:2] == m_link);
`else
    link_ok = 1'b1;
    sw_hit  = 1'b0;
`endif
    acc    = (kind == 0) || ((kind == 1) && eff && link_ok);
    sc_bad = (kind == 1) && !acc;

    op_valid = 1'b1; op_ll = (kind == 0); op_sc = (kind == 1); op_sw = (kind == 2);
    addr = a; wdata = wd; wb_llbit_we = wbwe; wb_llbit_val = wbval; llbit_cur = model_ll;
    #1 chk1("stall_at_issue", stall_req, acc);
    @(negedge clk);
    if (wbwe) model_ll = wbval;
    idle_inputs();
    if (!acc) begin
      chk1("bus_req_no_access", bus_req, 1'b0);
      chk1("result_valid_idle_op", result_valid, sc_bad);
      chk1("llbit_we_idle_op", llbit_we_o, sc_bad || sw_hit);
      if (sc_bad) chk32("sc_fail_result", result, 32'd0);
      if (sc_bad || sw_hit) begin
        chk1("llbit_val_clear", llbit_val_o, 1'b0);
        model_ll = 1'b0;
      end
      llbit_cur = model_ll;
      #1 chk1("stall_after_idle_op", stall_req, 1'b0);
      return;
    end
    done = 1'b0;
    for (int k = 1; k <= TO && !done; k++) begin
      chk1("bus_req_held", bus_req, 1'b1);
      chk1("bus_we", bus_we, kind == 1);
      chk32("bus_addr", bus_addr, a);
      if (kind == 1) chk32("bus_wdata", bus_wdata, wd);
      chk1("no_early_result", result_valid, 1'b0);
      bus_ack   = (k == ack_lat);
      bus_rdata = (k == ack_lat) ? rd : $urandom;
      #1 chk1("stall_in_bus", stall_req, 1'b1);
      @(negedge clk);
      bus_ack = 1'b0;
      if (k == ack_lat) done = 1'b1;
    end
    if (done) begin
      chk1("result_valid_done", result_valid, 1'b1);
      chk32("result_done", result, (kind == 0) ? rd : 32'd1);
      chk1("llbit_we_done", llbit_we_o, 1'b1);
      chk1("llbit_val_done", llbit_val_o, kind == 0);
      chk1("bus_req_dropped", bus_req, 1'b0);
      chk1("no_err_on_success", bus_err, 1'b0);
      #1 chk1("stall_in_done", stall_req, 1'b0);
      model_ll = (kind == 0);
      if (kind == 0) begin
        m_link   = a[31:2];
        m_link_v = 1'b1;
      end
      llbit_cur = model_ll;
      @(negedge clk);
      chk1("result_pulse_one_cycle", result_valid, 1'b0);
      chk1("llbit_pulse_one_cycle", llbit_we_o, 1'b0);
    end else begin
      chk1("timeout_bus_err", bus_err, 1'b1);
      chk1("timeout_bus_req", bus_req, 1'b0);
      chk1("timeout_no_result", result_valid, 1'b0);
      chk1("timeout_no_llbit", llbit_we_o, 1'b0);
      @(negedge clk);
      chk1("bus_err_one_cycle", bus_err, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    addr = '0; wdata = '0; bus_rdata = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_result_valid", result_valid, 1'b0);
    chk32("rst_result", result, 32'd0);
    chk32("rst_bus_addr", bus_addr, 32'd0);
    chk1("rst_llbit_we", llbit_we_o, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // LL with ack two cycles after accept, then a successful SC with single-cycle ack.
    run_op(0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    run_op(1, 32'h100, 32'h55, 1, 32'h0, 1'b0, 1'b0);
    // SC losing to a forwarded WB clear of the LLbit.
    run_op(0, 32'h100, 32'h0, 1, 32'h12345678, 1'b0, 1'b0);
    run_op(1, 32'h100, 32'h77, 1, 32'h0, 1'b1, 1'b0);
    // SC rescued by a forwarded WB set while the register still reads 0.
    run_op(0, 32'h100, 32'h0, 1, 32'hA5A5A5A5, 1'b0, 1'b0);
    run_op(1, 32'h100, 32'h99, TO, 32'h0, 1'b1, 1'b1);
    // Bus never answers.
    run_op(0, 32'h140, 32'h0, 0, 32'h0, 1'b0, 1'b0);

    // Flush coincident with bus_ack.
    op_valid = 1'b1; op_ll = 1'b1; addr = 32'h180;
    @(negedge clk);
    idle_inputs();
    chk1("flush_pre_bus_req", bus_req, 1'b1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk1("flush_no_result", result_valid, 1'b0);
    chk1("flush_no_llbit", llbit_we_o, 1'b0);
    chk1("flush_bus_req", bus_req, 1'b0);
    #1 chk1("flush_stall_idle", stall_req, 1'b0);

    // Flush in IDLE blocks acceptance.
    op_valid = 1'b1; op_ll = 1'b1; addr = 32'h1C0; flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk1("flush_idle_no_req", bus_req, 1'b0);
    @(negedge clk);
    chk1("flush_idle_still_no_req", bus_req, 1'b0);
    chk1("flush_idle_no_result", result_valid, 1'b0);

    // Link-address sequences; the model decides whether the check is built in.
    run_op(0, 32'h200, 32'h0, 1, 32'h11112222, 1'b0, 1'b0);
    run_op(2, 32'h200, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    run_op(1, 32'h200, 32'h33, 1, 32'h0, 1'b0, 1'b0);
    run_op(0, 32'h200, 32'h0, 1, 32'h44445555, 1'b0, 1'b0);
    run_op(1, 32'h204, 32'h66, 1, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int gap;
      run_op(int'($urandom_range(0, 2)), 32'h200 + 32'($urandom_range(0, 3)) * 4, $urandom,
             int'($urandom_range(0, TO)), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk1("gap_no_result", result_valid, 1'b0);
        chk1("gap_no_req", bus_req, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
